gascon_permutation_ctrl: RTL
============================

// Module: gascon_permutation_ctrl
// PURPOSE
// Initiator that drives one Gascon round core through a full permutation.
// - Accepts a CWIDTH state plus a round count from the host; issues one round at a time to the core.
// - Per round: pulse core_reset, drive core_en/core_c/core_round, wait for core_done, capture core_cout.
// - Returns the permuted state to the host with a valid/ready handshake.
// PARAMETERS
// CWIDTH      320  permutation state width (multiple of 64)
// ROUND_W     16   width of core_round (matches round core round-port width)
// MAX_ROUNDS  12   full-permutation round count; round index range 0..MAX_ROUNDS-1
// RCNT_W      4    width of s_rounds; must hold MAX_ROUNDS
// TIMEOUT     255  max cycles CORE_RUN waits for core_done before ERROR
// PORTS
// clk         in   1        rising-edge clock
// reset_n     in   1        asynchronous, active-low reset
// s_valid     in   1        host request valid
// s_ready     out  1        controller can accept a request
// s_state     in   CWIDTH   input state
// s_rounds    in   RCNT_W   rounds to run (0..MAX_ROUNDS; larger values clamp)
// m_valid     out  1        result valid
// m_ready     in   1        host accepts result
// m_state     out  CWIDTH   permuted state
// err         out  1        sticky: core timed out
// core_reset  out  1        active-high reset to round core
// core_en     out  1        round core enable
// core_c      out  CWIDTH   state to round core
// core_round  out  ROUND_W  round index to round core
// core_cout   in   CWIDTH   round core result
// core_done   in   1        round core done (level, held until core_reset)
// BEHAVIOUR
// Reset values: state=BOOT; state_reg, m_state, core_c, core_round = 0; round_idx, remaining, wdog = 0.
// - Reset outputs: s_ready=0, m_valid=0, err=0, core_en=0, core_reset=1.
// State decodes:
// - core_reset=1 in BOOT, IDLE, CORE_RST, OUT, ERROR; core_reset=0 in CORE_RUN only.
// - core_en=1 only in CORE_RUN.
// - s_ready = (state==IDLE); m_valid = (state==OUT).
// - core_c = state_reg and core_round = round_idx (zero-extended), both registered and stable through CORE_RUN.
// Transitions:
// - BOOT -> IDLE after 1 cycle.
// - IDLE: on s_valid&s_ready, set n = min(s_rounds, MAX_ROUNDS), state_reg <= s_state,
//   round_idx <= MAX_ROUNDS-n, remaining <= n. Go to CORE_RST if n>0, else OUT (state unchanged).
// - CORE_RST: 1 cycle, wdog <= 0 -> CORE_RUN.
// - CORE_RUN: wdog increments every cycle.
//   - On core_done: state_reg <= core_cout, round_idx += 1, remaining -= 1; remaining==1 -> OUT, else CORE_RST.
//   - core_done with wdog==TIMEOUT in the same cycle: done wins.
//   - wdog==TIMEOUT without core_done -> ERROR.
// - OUT: m_state = state_reg held stable while m_ready=0; on m_ready -> IDLE.
//   - s_ready=0 in OUT; a back-to-back request is accepted no earlier than the following IDLE cycle (1-cycle bubble).
// - ERROR: err=1, s_ready=0, m_valid=0; exit only via reset_n.
// Latency: Lc = cycles from core_en high to core_done sampled high.
// - m_valid rises n*(1+Lc) cycles after the accept edge; n=0 gives 1 cycle.
// Reset mid-operation:
// - reset_n low forces BOOT immediately; core_reset is asserted asynchronously.
// - The in-flight permutation is dropped; no m_valid for it.
// core_done while not in CORE_RUN is ignored.
// TESTING
// 1. Behavioural core (Lc=5, cout=c+round). Send s_rounds=12, s_state=0.
//    -> core_round 0..11 in order; m_valid at cycle 72; m_state = 66.
// 2. s_rounds=6 -> core_round 6..11 only; core_reset pulses 6 times (1 cycle each).
// 3. s_rounds=0, s_state=0xABCD -> m_valid 1 cycle after accept, m_state=0xABCD, core_en never high.
//    s_rounds=15 -> identical to test 1 (clamped).
// 4. m_ready held low 10 cycles in OUT -> m_valid and m_state stable; s_ready=0.
//    m_ready=1 -> IDLE next cycle, then s_ready=1.
// 5. Core model never asserts done, TIMEOUT=255 -> err=1 at CORE_RUN cycle 255, stays set.
//    Pulse reset_n -> err=0, BOOT -> IDLE.
// 6. reset_n low during round 3 of 12 -> core_reset=1 and core_en=0 asynchronously, no m_valid.
//    A new request then completes normally.

Source files
------------

// File: rtl/gascon_permutation_ctrl.sv
// rtl/gascon_permutation_ctrl.sv - sequences a Gascon round core through a full permutation
module gascon_permutation_ctrl #(
    parameter int CWIDTH     = 320,
    parameter int ROUND_W    = 16,
    parameter int MAX_ROUNDS = 12,
    parameter int RCNT_W     = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [CWIDTH-1:0]   s_state,
    input  logic [RCNT_W-1:0]   s_rounds,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [CWIDTH-1:0]   m_state,
    output logic                err,
    output logic                core_reset,
    output logic                core_en,
    output logic [CWIDTH-1:0]   core_c,
    output logic [ROUND_W-1:0]  core_round,
    input  logic [CWIDTH-1:0]   core_cout,
    input  logic                core_done
);

    // round_idx must reach MAX_ROUNDS after the last round, so size it for MAX_ROUNDS inclusive
    localparam int IDX_W  = $clog2(MAX_ROUNDS + 1);
    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_CORE_RST,
        ST_CORE_RUN,
        ST_OUT,
        ST_ERROR
    } state_e;

    state_e              state_q;
    logic [CWIDTH-1:0]   state_reg_q;
    logic [IDX_W-1:0]    round_idx_q;
    logic [IDX_W-1:0]    remaining_q;
    logic [WDOG_W-1:0]   wdog_q;

    logic [31:0]         rounds_u;
    logic [IDX_W-1:0]    req_n_d;

    // Clamp the requested round count to a full permutation
    always_comb begin
        rounds_u = 32'(s_rounds);
        if (rounds_u > 32'(MAX_ROUNDS)) begin
            req_n_d = IDX_W'(MAX_ROUNDS);
        end else begin
            req_n_d = IDX_W'(rounds_u);
        end
    end

    // Main sequencer: one CORE_RST/CORE_RUN pair per round, watchdog guards a stuck core
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_BOOT;
            state_reg_q <= '0;
            round_idx_q <= '0;
            remaining_q <= '0;
            wdog_q      <= '0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (s_valid) begin
                        state_reg_q <= s_state;
                        // a reduced-round request runs the tail rounds of the schedule
                        round_idx_q <= IDX_W'(MAX_ROUNDS) - req_n_d;
                        remaining_q <= req_n_d;
                        state_q     <= (req_n_d != '0) ? ST_CORE_RST : ST_OUT;
                    end
                end
                ST_CORE_RST: begin
                    wdog_q  <= '0;
                    state_q <= ST_CORE_RUN;
                end
                ST_CORE_RUN: begin
                    wdog_q <= wdog_q + WDOG_W'(1);
                    // done is checked first so a result on the timeout cycle is still taken
                    if (core_done) begin
                        state_reg_q <= core_cout;
                        round_idx_q <= round_idx_q + IDX_W'(1);
                        remaining_q <= remaining_q - IDX_W'(1);
                        state_q     <= (remaining_q == IDX_W'(1)) ? ST_OUT : ST_CORE_RST;
                    end else if (wdog_q == WDOG_W'(TIMEOUT)) begin
                        state_q <= ST_ERROR;
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    state_q <= ST_ERROR;
                end
                default: begin
                    state_q <= ST_BOOT;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registers; the reset value of state_q makes core_reset
    // assert as soon as reset_n falls, without waiting for a clock
    assign s_ready    = (state_q == ST_IDLE);
    assign m_valid    = (state_q == ST_OUT);
    assign err        = (state_q == ST_ERROR);
    assign core_en    = (state_q == ST_CORE_RUN);
    assign core_reset = (state_q != ST_CORE_RUN);
    assign m_state    = state_reg_q;
    assign core_c     = state_reg_q;
    assign core_round = {{(ROUND_W - IDX_W){1'b0}}, round_idx_q};

endmodule
